fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the address of the first instruction fetched after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 mem_req  output  1  SHALL request a byte read from instruction memory.
REQ-005 mem_addr  output  16  SHALL be the byte address of the current read.
REQ-006 mem_rdata  input  8  SHALL be the read byte, valid when mem_ready=1.
REQ-007 mem_ready  input  1  SHALL complete the current read in the cycle it is high while mem_req=1.
REQ-008 instr  output  16  SHALL be the fetched instruction register.
REQ-009 opcode  output  4  SHALL equal instr[15:12] combinationally; this is the decode stage's opcode input.
REQ-010 instr_valid  output  1  SHALL indicate that instr, opcode and pc_out hold a complete instruction.
REQ-011 instr_ack  input  1  SHALL signal that downstream has consumed the held instruction.
REQ-012 pc_out  output  16  SHALL be the byte address of the held instruction.
REQ-013 jump_en  input  1  SHALL select redirection to jump_target when sampled with instr_ack (driven from the decode wpc flag).
REQ-014 jump_target  input  16  SHALL be the redirect byte address.

Function
REQ-015 The FSM SHALL have three states: FETCH_HI, FETCH_LO and HOLD.
REQ-016 In FETCH_HI, mem_req SHALL be 1 and mem_addr SHALL equal pc.
REQ-017 In FETCH_LO, mem_req SHALL be 1 and mem_addr SHALL equal pc+1 (mod 2^16).
REQ-018 In HOLD, mem_req SHALL be 0.
REQ-019 FETCH_HI with mem_ready=1 SHALL latch instr[15:8]=mem_rdata and go to FETCH_LO; otherwise the FSM SHALL stay in FETCH_HI.
REQ-020 FETCH_LO with mem_ready=1 SHALL latch instr[7:0]=mem_rdata, set instr_valid=1 and go to HOLD; otherwise the FSM SHALL stay in FETCH_LO.
REQ-021 instr_valid SHALL be 1 exactly while in HOLD; instr and pc_out SHALL be stable throughout HOLD.
REQ-022 HOLD with instr_ack=1 and jump_en=1 SHALL load pc=jump_target and go to FETCH_HI.
REQ-023 HOLD with instr_ack=1 and jump_en=0 SHALL load pc=pc+2 (wraps 16'hFFFE -> 16'h0000) and go to FETCH_HI.
REQ-024 HOLD with instr_ack=0 SHALL hold all state, regardless of jump_en.
REQ-025 jump_en and instr_ack SHALL be ignored outside HOLD.
REQ-026 mem_ready SHALL be ignored while mem_req=0.
REQ-027 Odd jump targets SHALL be used unmodified; pc+1 SHALL wrap 16'hFFFF -> 16'h0000.
REQ-028 Minimum latency SHALL be 2 cycles from entering FETCH_HI to instr_valid=1 (mem_ready high every cycle).
REQ-029 Minimum throughput SHALL be one instruction per 3 cycles with instr_ack tied high.
REQ-030 pc_out SHALL equal pc.

Reset
REQ-031 When rst=1 at a clock edge, state SHALL be set to FETCH_HI, pc to RESET_PC, instr to 16'h0000 (opcode 0) and instr_valid to 0.
REQ-032 During the reset cycle mem_req SHALL be 0.
REQ-033 Reset in any state, including mid-fetch or in HOLD, SHALL abandon the in-flight read and discard any ack or jump seen in the same cycle.

Structure
REQ-034 A shared package SHALL hold: the state enum (FETCH_HI, FETCH_LO, HOLD), the opcode field bounds (OPC_MSB=15, OPC_LSB=12) and the 16-bit address width constant.
REQ-035 The block SHALL be a single module with no sub-module; opcode SHALL feed the existing decode ROM directly.

Verification
REQ-036 Reset with RESET_PC=16'h0010, memory bytes 10:12, 11:34, mem_ready always high -> mem_addr=16'h0010 then 16'h0011; instr=16'h1234, opcode=4'h1, pc_out=16'h0010, instr_valid=1 on the 3rd cycle after reset release.
REQ-037 mem_ready held low 4 cycles in FETCH_LO -> mem_addr stays pc+1, instr_valid stays 0; completion occurs on the first ready cycle.
REQ-038 instr_ack held low 5 cycles in HOLD, with jump_en toggling -> instr, pc_out and instr_valid unchanged, mem_req=0.
REQ-039 HOLD at pc=16'h0020 with instr_ack=1, jump_en=1, jump_target=16'h0081 -> next mem_addr=16'h0081 then 16'h0082.
REQ-040 pc=16'hFFFE with instr_ack=1, jump_en=0 -> next fetch address 16'h0000; and pc=16'hFFFF fetch -> low byte read from 16'h0000.
REQ-041 rst asserted in FETCH_LO -> next cycle instr_valid=0, instr=16'h0000, mem_req=0; then refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, opcode field bounds and address width.
package fetch_unit_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        HOLD     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: byte-wide instruction memory read port plus the held-instruction
// handshake towards decode. master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic [7:0]               mem_rdata;
    logic                     mem_ready;
    logic [INSTR_W-1:0]       instr;
    logic [OPC_MSB-OPC_LSB:0] opcode;
    logic                     instr_valid;
    logic                     instr_ack;
    logic [ADDR_W-1:0]        pc_out;
    logic                     jump_en;
    logic [ADDR_W-1:0]        jump_target;

    modport master (
        output mem_req, mem_addr, instr, opcode, instr_valid, pc_out,
        input  mem_rdata, mem_ready, instr_ack, jump_en, jump_target
    );

    modport slave (
        input  mem_req, mem_addr, instr, opcode, instr_valid, pc_out,
        output mem_rdata, mem_ready, instr_ack, jump_en, jump_target
    );

endinterface

// File: rtl/fetch_unit.sv
// Two-byte instruction fetch: high byte at pc, low byte at pc+1, then hold until acked.
// Latency 2 cycles to instr_valid with memory always ready; stalls on mem_ready=0 and instr_ack=0.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            FETCH_HI: begin
                if (bus.mem_ready) begin
                    instr_d[15:8] = bus.mem_rdata;
                    state_d       = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (bus.mem_ready) begin
                    instr_d[7:0] = bus.mem_rdata;
                    valid_d      = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                // Redirect or advance only once decode has taken the instruction.
                if (bus.instr_ack) begin
                    pc_d    = bus.jump_en ? bus.jump_target : pc_q + ADDR_W'(2);
                    valid_d = 1'b0;
                    state_d = FETCH_HI;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = FETCH_HI;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_HI;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // No read is issued while reset is asserted, even though the state reads FETCH_HI.
    assign bus.mem_req     = ~rst & (state_q != HOLD);
    assign bus.mem_addr    = (state_q == FETCH_LO) ? pc_q + ADDR_W'(1) : pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions are queued as fetches start and
// checked by a monitor whenever instr_valid rises; bus timing is checked inline.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic seen;
    exp_t sbq[$];
    logic [7:0] mem [0:65535];

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(16'h0010)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Scoreboard monitor: one pop per rising instr_valid.
    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1 && !seen) begin
            if (sbq.size() == 0) begin
                chk("unexpected_instr", bus.instr, 16'hxxxx);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("instr", bus.instr, e.instr);
                chk("opcode", {12'h000, bus.opcode}, {12'h000, e.instr[15:12]});
                chk("pc_out", bus.pc_out, e.pc);
            end
        end
        seen = (bus.instr_valid === 1'b1);
    end

    // Called on a negedge while in HOLD: ack with optional jump, queue expected result.
    task automatic redirect(input logic jmp, input logic [15:0] tgt, input logic push,
                            input logic [15:0] e_instr, input logic [15:0] e_pc);
        exp_t e;
        bus.instr_ack   = 1'b1;
        bus.jump_en     = jmp;
        bus.jump_target = tgt;
        if (push) begin
            e.instr = e_instr;
            e.pc    = e_pc;
            sbq.push_back(e);
        end
    endtask

    task automatic fetch_seq(input logic [15:0] a_hi, input logic [15:0] a_lo);
        nxt();
        bus.instr_ack = 1'b0;
        bus.jump_en   = 1'b0;
        chk("hi_addr", bus.mem_addr, a_hi);
        chk("hi_req", {15'h0, bus.mem_req}, 16'h1);
        chk("hi_valid", {15'h0, bus.instr_valid}, 16'h0);
        nxt();
        chk("lo_addr", bus.mem_addr, a_lo);
        chk("lo_req", {15'h0, bus.mem_req}, 16'h1);
        nxt();
        chk("hold_valid", {15'h0, bus.instr_valid}, 16'h1);
        chk("hold_req", {15'h0, bus.mem_req}, 16'h0);
    endtask

    initial begin
        exp_t e;
        vectors     = 0;
        miscompares = 0;
        seen        = 1'b0;
        rst         = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.instr_ack   = 1'b0;
        bus.jump_en     = 1'b0;
        bus.jump_target = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34;
        mem[16'h0012] = 8'h56; mem[16'h0013] = 8'h78;
        mem[16'h0020] = 8'h9A; mem[16'h0021] = 8'hBC;
        mem[16'h0081] = 8'hDE; mem[16'h0082] = 8'hF0;
        mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2;
        mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hD4;
        mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22;

        nxt();
        nxt();
        chk("rst_req", {15'h0, bus.mem_req}, 16'h0);
        chk("rst_valid", {15'h0, bus.instr_valid}, 16'h0);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_opcode", {12'h000, bus.opcode}, 16'h0000);
        e.instr = 16'h1234; e.pc = 16'h0010; sbq.push_back(e);
        rst = 1'b0;
        #1;
        chk("first_addr", bus.mem_addr, 16'h0010);
        chk("first_req", {15'h0, bus.mem_req}, 16'h1);
        nxt();
        chk("second_addr", bus.mem_addr, 16'h0011);
        chk("second_valid", {15'h0, bus.instr_valid}, 16'h0);
        nxt();

        // Held instruction must stay put while unacked, whatever jump_en does.
        for (int i = 0; i < 6; i++) begin
            chk("hold_instr", bus.instr, 16'h1234);
            chk("hold_pc", bus.pc_out, 16'h0010);
            chk("hold_valid", {15'h0, bus.instr_valid}, 16'h1);
            chk("hold_req", {15'h0, bus.mem_req}, 16'h0);
            bus.jump_en     = ~bus.jump_en;
            bus.jump_target = 16'h0400;
            if (i < 5) nxt();
        end
        redirect(1'b0, 16'h0400, 1'b1, 16'h5678, 16'h0012);
        nxt();
        bus.instr_ack = 1'b0;
        bus.jump_en   = 1'b0;
        chk("seq_addr", bus.mem_addr, 16'h0012);
        nxt();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_addr", bus.mem_addr, 16'h0013);
            chk("stall_req", {15'h0, bus.mem_req}, 16'h1);
            chk("stall_valid", {15'h0, bus.instr_valid}, 16'h0);
            if (i < 4) nxt();
        end
        bus.mem_ready = 1'b1;
        nxt();
        chk("stall_done", {15'h0, bus.instr_valid}, 16'h1);

        redirect(1'b1, 16'h0020, 1'b1, 16'h9ABC, 16'h0020);
        fetch_seq(16'h0020, 16'h0021);
        redirect(1'b1, 16'h0081, 1'b1, 16'hDEF0, 16'h0081);
        fetch_seq(16'h0081, 16'h0082);
        redirect(1'b1, 16'hFFFE, 1'b1, 16'hA1B2, 16'hFFFE);
        fetch_seq(16'hFFFE, 16'hFFFF);
        redirect(1'b0, 16'h0000, 1'b1, 16'hC3D4, 16'h0000);
        fetch_seq(16'h0000, 16'h0001);
        redirect(1'b1, 16'hFFFF, 1'b1, 16'hB2C3, 16'hFFFF);
        fetch_seq(16'hFFFF, 16'h0000);

        // Reset mid-fetch with a stray ack/jump present: the read must be abandoned.
        redirect(1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        nxt();
        bus.instr_ack = 1'b0;
        bus.jump_en   = 1'b0;
        chk("pre_rst_addr", bus.mem_addr, 16'h0040);
        nxt();
        chk("pre_rst_lo_addr", bus.mem_addr, 16'h0041);
        rst             = 1'b1;
        bus.instr_ack   = 1'b1;
        bus.jump_en     = 1'b1;
        bus.jump_target = 16'h0300;
        #1;
        chk("rst_cycle_req", {15'h0, bus.mem_req}, 16'h0);
        nxt();
        chk("post_rst_valid", {15'h0, bus.instr_valid}, 16'h0);
        chk("post_rst_instr", bus.instr, 16'h0000);
        chk("post_rst_req", {15'h0, bus.mem_req}, 16'h0);
        rst           = 1'b0;
        bus.instr_ack = 1'b0;
        bus.jump_en   = 1'b0;
        e.instr = 16'h1234; e.pc = 16'h0010; sbq.push_back(e);
        #1;
        chk("refetch_addr", bus.mem_addr, 16'h0010);
        nxt();
        chk("refetch_lo_addr", bus.mem_addr, 16'h0011);
        nxt();
        chk("refetch_valid", {15'h0, bus.instr_valid}, 16'h1);
        nxt();
        nxt();
        chk("sb_empty", 16'(sbq.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
